// File: rtl/mul_app_pkg.sv
// Shared constants, the shift-field width helper and the stage payload types
// for the pipelined log-style approximate multiplier.
package mul_app_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_K      = 6;
  localparam int DEF_TAG_W  = 4;

  // Wide enough for the sum of both operand shifts, 0 .. 2*(data_w-k).
  function automatic int sh_width(input int data_w, input int k);
    return $clog2(2 * (data_w - k) + 1);
  endfunction

  localparam int SH_W = sh_width(DEF_DATA_W, DEF_K);

  // op_a/op_b hold the full magnitude in exact mode, the K-bit mantissa otherwise.
  typedef struct packed {
    logic                  valid;
    logic                  neg;
    logic                  exact;
    logic [DEF_DATA_W-1:0] op_a;
    logic [DEF_DATA_W-1:0] op_b;
    logic [SH_W-1:0]       sh_a;
    logic [SH_W-1:0]       sh_b;
    logic [DEF_TAG_W-1:0]  tag;
  } s1_payload_t;

  typedef struct packed {
    logic                    valid;
    logic                    neg;
    logic [2*DEF_DATA_W-1:0] prod;
    logic [SH_W-1:0]         shift;
    logic [DEF_TAG_W-1:0]    tag;
  } s2_payload_t;

endpackage

// File: rtl/mul_app_lead_enc.sv
// Leading-one encoder: truncates a magnitude to a K-bit mantissa whose LSB is
// forced to 1, and reports how far the mantissa must later be shifted back.
module mul_app_lead_enc
  import mul_app_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K
) (
  input  logic [DATA_W-1:0]                mag,
  output logic [K-1:0]                     m,
  output logic [sh_width(DATA_W, K)-1:0]   sh
);

  localparam int SHW = sh_width(DATA_W, K);
  localparam int PW  = $clog2(DATA_W);

  logic [PW-1:0] p;
  logic [K-1:0]  cand [DATA_W];

  // One candidate mantissa per possible leading-one position.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_cand
      if (gi >= K) begin : g_trunc
        assign cand[gi] = {mag[gi -: K-1], 1'b1};
      end else begin : g_keep
        assign cand[gi] = mag[K-1:0];
      end
    end
  endgenerate

  always_comb begin
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (mag[i]) p = PW'(i);
    end
    m  = cand[p];
    sh = '0;
    if (int'(p) >= K) sh = SHW'(int'(p) - K + 1);
  end

endmodule

// File: rtl/mul_app_pipe.sv
// Three-stage valid/ready approximate/exact multiplier: encode, multiply,
// shift+sign. All stages advance together on en and hold together on stall.
module mul_app_pipe
  import mul_app_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                in_signed,
  input  logic                in_exact,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_p,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int PW   = 2 * DATA_W;
  localparam int LSHW = sh_width(DATA_W, K);

  // Stage payloads are sized by the package defaults; narrower builds fit inside.
  generate
    if (DATA_W > DEF_DATA_W || TAG_W > DEF_TAG_W || LSHW > SH_W ||
        K < 3 || K > DATA_W - 1) begin : g_param_check
      $error("mul_app_pipe: parameters outside the supported range");
    end
  endgenerate

  logic                     en;
  logic [1:0][DATA_W-1:0]   opnd;
  logic [1:0]               sgn;
  logic [1:0][DATA_W-1:0]   mag;
  logic [1:0][K-1:0]        mant;
  logic [1:0][LSHW-1:0]     sh;

  s1_payload_t              s1_reg, s1_next;
  s2_payload_t              s2_reg, s2_next;
  logic [PW-1:0]            mul_a, mul_b, shifted;
  logic                     out_valid_reg;
  logic [PW-1:0]            out_p_reg, out_p_next;
  logic [TAG_W-1:0]         out_tag_reg, out_tag_next;

  assign en       = !out_valid_reg || out_ready;
  assign in_ready = en;

  assign opnd[0] = in_a;
  assign opnd[1] = in_b;

  // Sign-magnitude front end; the most negative value maps to 2^(DATA_W-1).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign sgn[gi] = in_signed & opnd[gi][DATA_W-1];
      assign mag[gi] = sgn[gi] ? -opnd[gi] : opnd[gi];

      mul_app_lead_enc #(
        .DATA_W (DATA_W),
        .K      (K)
      ) u_enc (
        .mag (mag[gi]),
        .m   (mant[gi]),
        .sh  (sh[gi])
      );
    end
  endgenerate

  always_comb begin
    s1_next       = '0;
    s1_next.valid = in_valid;
    s1_next.neg   = sgn[0] ^ sgn[1];
    s1_next.exact = in_exact;
    s1_next.op_a  = in_exact ? DEF_DATA_W'(mag[0]) : DEF_DATA_W'(mant[0]);
    s1_next.op_b  = in_exact ? DEF_DATA_W'(mag[1]) : DEF_DATA_W'(mant[1]);
    s1_next.sh_a  = SH_W'(sh[0]);
    s1_next.sh_b  = SH_W'(sh[1]);
    s1_next.tag   = DEF_TAG_W'(in_tag);
  end

  // One multiplier serves both modes: mantissas are simply narrow magnitudes.
  always_comb begin
    mul_a         = PW'(s1_reg.op_a[DATA_W-1:0]);
    mul_b         = PW'(s1_reg.op_b[DATA_W-1:0]);
    s2_next       = '0;
    s2_next.valid = s1_reg.valid;
    s2_next.neg   = s1_reg.neg;
    s2_next.prod  = (2*DEF_DATA_W)'(mul_a * mul_b);
    s2_next.shift = s1_reg.exact ? '0 : s1_reg.sh_a + s1_reg.sh_b;
    s2_next.tag   = s1_reg.tag;
  end

  // A zero product stays zero after negation, so no -0 can appear.
  always_comb begin
    shifted      = s2_reg.prod[PW-1:0] << s2_reg.shift;
    out_p_next   = '0;
    out_tag_next = '0;
    if (s2_reg.valid) begin
      out_p_next   = s2_reg.neg ? -shifted : shifted;
      out_tag_next = s2_reg.tag[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg        <= '0;
      s2_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_p_reg     <= '0;
      out_tag_reg   <= '0;
    end else if (en) begin
      s1_reg        <= s1_next;
      s2_reg        <= s2_next;
      out_valid_reg <= s2_reg.valid;
      out_p_reg     <= out_p_next;
      out_tag_reg   <= out_tag_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_mul_app_pipe.sv
// Self-checking bench for mul_app_pipe: directed corner cases, backpressure,
// mid-stream reset and a randomized stream scored against a value-level model.
module tb_mul_app_pipe;

  localparam int DW = 16;
  localparam int KK = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, in_exact;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_p;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] got_tags[$];
  bit         rand_done;

  mul_app_pipe #(.DATA_W(DW), .K(KK), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_exact  (in_exact),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Approximation as a value: keep K significant bits, force the lowest kept bit to 1.
  function automatic longint approx_val(input longint x);
    int p = 0;
    int d;
    for (int i = 0; i < DW; i++) if (((x >> i) & 1) != 0) p = i;
    if (p >= KK) begin
      d = p - KK + 1;
      return ((x >> d) | 1) << d;
    end
    return x;
  endfunction

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic e);
    longint ma, mb, r;
    bit na, nb;
    na = s && a[15];
    nb = s && b[15];
    ma = na ? 65536 - longint'(a) : longint'(a);
    mb = nb ? 65536 - longint'(b) : longint'(b);
    if (!e) begin
      ma = approx_val(ma);
      mb = approx_val(mb);
    end
    r = ma * mb;
    if (na ^ nb) r = -r;
    return r[31:0];
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] corner [5];
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 63));
      2:       return corner[$urandom_range(0, 4)];
      default: return 16'($urandom) >> $urandom_range(0, 15);
    endcase
  endfunction

  // Scoreboard: record accepted inputs, compare every transferred result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", out_p, e.p);
          check("tag", out_tag, e.tag);
          $display("txn tag=%0d p=%08h expected=%08h", out_tag, out_p, e.p);
        end
        got_tags.push_back(out_tag);
      end
      if (in_valid && in_ready) begin
        e.p   = model(in_a, in_b, in_signed, in_exact);
        e.tag = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic e, input logic [3:0] t);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_exact = e; in_tag = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic e, input logic [31:0] exp);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(a, b, s, e, 4'hA);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check(name, out_p, exp);
    check({name, "_tag"}, out_tag, 4'hA);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_p;
    logic [3:0]  hold_t;
    int stale;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_exact = 1'b0; in_tag = '0; out_ready = 1'b1; rand_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_p", out_p, 32'd0);
    check("reset_out_tag", out_tag, 4'd0);
    check("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    run_one("approx_1000x3",  16'd1000,  16'd3,     1'b0, 1'b0, 32'd3024);
    run_one("approx_small",   16'd45,    16'd63,    1'b0, 1'b0, 32'd2835);
    run_one("exact_small",    16'd45,    16'd63,    1'b0, 1'b1, 32'd2835);
    run_one("approx_zero",    16'd0,     16'hFFFF,  1'b0, 1'b0, 32'd0);
    run_one("approx_max",     16'hFFFF,  16'hFFFF,  1'b0, 1'b0, 32'hF8100000);
    run_one("exact_max",      16'hFFFF,  16'hFFFF,  1'b0, 1'b1, 32'hFFFE0001);
    run_one("signed_approx",  16'hFC18,  16'd3,     1'b1, 1'b0, 32'hFFFFF430);
    run_one("signed_minmin",  16'h8000,  16'h8000,  1'b1, 1'b1, 32'h40000000);
    run_one("signed_zero",    16'h0000,  16'hFFFF,  1'b1, 1'b0, 32'd0);
    drain();

    // Backpressure: three results fill the pipe, the fourth input must wait.
    @(posedge clk); #1;
    out_ready = 1'b0;
    got_tags.delete();
    for (int t = 1; t <= 3; t++) send(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 4'(t));
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_head_tag", out_tag, 4'd1);
    hold_p = out_p;
    hold_t = out_tag;
    in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_signed = 1'b0;
    in_exact = 1'b0; in_tag = 4'd4;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_p", out_p, hold_p);
      check("bp_hold_tag", out_tag, hold_t);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send(in_a, in_b, 1'b0, 1'b0, 4'd4);
    send(rand_op(), rand_op(), 1'b1, 1'b0, 4'd5);
    for (int n = 0; n < 30 && got_tags.size() < 5; n++) begin
      @(posedge clk); #1;
    end
    check("bp_count", 64'(got_tags.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_tags.size(); i++) check("bp_order", got_tags[i], 4'(i + 1));
    drain();

    // Reset with three transactions in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int t = 6; t <= 8; t++) send(rand_op(), rand_op(), 1'b0, 1'b0, 4'(t));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_p", out_p, 32'd0);
    check("midrst_out_tag", out_tag, 4'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);
    run_one("after_reset", 16'd1000, 16'd3, 1'b0, 1'b0, 32'd3024);
    drain();

    // Randomized stream with random gaps and random downstream stalls.
    fork
      begin
        for (int n = 0; n < 250; n++) begin
          send(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 4'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_app_pipe.md
Name: mul_app_pipe

Overview:
Parametrised, pipelined successor to the combinational log-style approximate multiplier.
- Approximation: per operand, leading-one detection, truncation to a K-bit mantissa with the appended LSB forced to 1, small multiply, then barrel shift.
- New over the previous generation: generic operand width and mantissa size, runtime exact/approximate mode, signed (sign-magnitude) operation, a tag, and a 3-stage valid/ready pipeline.
- Sits as the multiply element inside systolic-array PEs, feeding the accumulator.

Parameters:
- DATA_W, 16, operand width in bits (≥ K+1).
- K, 6, retained mantissa bits in approximate mode, including the forced-1 LSB (3..DATA_W-1).
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, input transaction valid.
- in_ready, out, 1, pipeline can accept an input this cycle.
- in_a, in, DATA_W, operand A.
- in_b, in, DATA_W, operand B.
- in_signed, in, 1, 1 = operands are two's complement.
- in_exact, in, 1, 1 = exact product; 0 = approximate.
- in_tag, in, TAG_W, sideband, returned unchanged with the result.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_p, out, 2*DATA_W, product; two's complement when signed.
- out_tag, out, TAG_W, tag of this result.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits cleared; out_valid=0, out_p=0, out_tag=0. Any in-flight data is discarded, and no result emerges after reset is released.
- Pipeline enable: en = !out_valid || out_ready. Also in_ready = en (combinational). Every stage advances only when en=1; when en=0 all stages hold.
- Handshake: an input is accepted when in_valid && in_ready. A result is transferred when out_valid && out_ready. out_p and out_tag are stable while out_valid=1 && out_ready=0.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput: 1 per cycle. Results come out in order. Bubbles are not collapsed.
- S1 (register + encode):
  - mag = (signed && msb) ? -x : x, as DATA_W-bit unsigned. The most negative value maps to 2^(DATA_W-1).
  - neg = sA ^ sB.
  - p = index of the leading one of mag (0 if mag = 0).
  - sh = (p ≥ K) ? p-K+1 : 0.
  - M = (p ≥ K) ? {mag[p -: K-1], 1'b1} : mag[K-1:0].
- S2 (multiply):
  - Approximate: prod = M_A*M_B (2K bits); shift = sh_A+sh_B.
  - Exact: prod = mag_A*mag_B (2*DATA_W bits); shift = 0.
- S3 (shift + sign): r = prod << shift, truncated to 2*DATA_W bits. The result cannot overflow for K ≤ DATA_W-1. out_p = neg ? -r : r.
- Zero operand gives out_p = 0 in both modes, including the signed case (no -0).
- Operands with p < K give an approximate result equal to the exact result.
- Mode, sign and tag travel with their own transaction. Mixed modes back to back are legal.
- Simultaneous accept and transfer in the same cycle is legal and happens at full rate.

Decomposition:
- Package mul_app_pkg holds:
  - default DATA_W/K constants;
  - a function clog2-based width for the shift field (SH_W = clog2(2*(DATA_W-K)+1));
  - the S1→S2 and S2→S3 stage payload structs (valid, neg, M/mag, sh, exact, tag).
- Sub-module mul_app_lead_enc: combinational, parametrised by DATA_W and K. Input mag; outputs M and sh. It is instantiated twice in S1.

Test Plan:
(DATA_W=16, K=6, out_ready=1 unless stated)
- Approx unsigned: a=1000, b=3, exact=0 → out_p=3024 (M_A=63, sh_A=4), 3 cycles after acceptance.
- Small operands: a=45, b=63, approx → out_p=2835, identical to exact mode. a=0, b=0xFFFF → out_p=0.
- Extremes: a=b=0xFFFF unsigned, approx → out_p=0xF8100000. Same inputs, exact → out_p=0xFFFE0001.
- Signed approx: a=0xFC18 (-1000), b=3 → out_p=0xFFFFF430 (-3024). a=0x8000, b=0x8000, signed exact → out_p=0x40000000.
- Backpressure: stream 5 inputs with tags 1..5 while out_ready=0.
  - in_ready falls once 3 transactions are held.
  - out_p and out_tag stay stable while stalled.
  - After out_ready is raised, all 5 results arrive in tag order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 transactions in flight → out_valid=0 and out_p=0 next cycle. No stale results appear afterwards. The next input completes normally with 3-cycle latency.
